// File: rtl/priority16_req_queue_if.sv
// Request/dispatch bundle for priority16_req_queue (grant_cnt exists only with GRANT_CNT_EN).
interface priority16_req_queue_if;
  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = 4;

  logic             En;
  logic [N-1:0]     req_in;
  logic             clr_all;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     pending;
  logic             no_req;
`ifdef GRANT_CNT_EN
  logic [7:0]       grant_cnt;

  modport slave  (input  En, req_in, clr_all, out_ready,
                  output out_valid, out_idx, pending, no_req, grant_cnt);
  modport master (output En, req_in, clr_all, out_ready,
                  input  out_valid, out_idx, pending, no_req, grant_cnt);
`else
  modport slave  (input  En, req_in, clr_all, out_ready,
                  output out_valid, out_idx, pending, no_req);
  modport master (output En, req_in, clr_all, out_ready,
                  input  out_valid, out_idx, pending, no_req);
`endif
endinterface

// File: rtl/priority16_req_queue.sv
// Sticky 16-line request queue; highest pending index offered over valid/ready.
// Optional macro GRANT_CNT_EN adds an 8-bit completed-handshake counter.
module priority16_req_queue (
  input  logic                  clk,
  input  logic                  rst,
  priority16_req_queue_if.slave q_if
);
  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_pending;
  logic [N-1:0]     w_pending_nxt;
  logic [N-1:0]     w_clr_mask;
  logic             r_out_valid;
  logic             w_out_valid_nxt;
  logic [IDX_W-1:0] r_out_idx;
  logic [IDX_W-1:0] w_out_idx_nxt;
  logic [IDX_W-1:0] w_top_idx;
  logic             w_hs;

  // Highest set bit of the registered pending vector wins.
  always_comb begin
    w_top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_pending[i]) w_top_idx = IDX_W'(i);
    end
  end

  // A flush in the same cycle cancels the transfer.
  assign w_hs       = (r_state == OFFER) && q_if.out_ready && !q_if.clr_all;
  assign w_clr_mask = w_hs ? (N'(1) << r_out_idx) : '0;

  // Set after clear, so a same-cycle re-request of the granted bit survives.
  always_comb begin
    w_pending_nxt = (r_pending & ~w_clr_mask) | q_if.req_in;
    if (q_if.clr_all) w_pending_nxt = '0;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_out_idx_nxt   = r_out_idx;
    case (r_state)
      IDLE: begin
        w_out_valid_nxt = 1'b0;
        if (q_if.En && !q_if.clr_all && (r_pending != '0)) begin
          w_out_idx_nxt   = w_top_idx;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = OFFER;
        end
      end
      OFFER: begin
        if (q_if.clr_all || q_if.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_idx   <= w_out_idx_nxt;
    end
  end

  assign q_if.out_valid = r_out_valid;
  assign q_if.out_idx   = r_out_idx;
  assign q_if.pending   = r_pending;
  assign q_if.no_req    = (r_pending == '0);

`ifdef GRANT_CNT_EN
  logic [7:0] r_grant_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_grant_cnt <= '0;
    else if (w_hs) r_grant_cnt <= r_grant_cnt + 8'd1;
  end

  assign q_if.grant_cnt = r_grant_cnt;
`endif
endmodule
